// File: rtl/snake_body_tracker_if.sv
// -----------------------------------------------------------------------------
// snake_body_tracker_if
//   Occupancy-query handshake between a requester (master) and the snake body
//   tracker (slave).
//
//   query_start_i        : start an occupancy query (master -> slave)
//   query_x_i, query_y_i : cell to query, sampled with the start
//   query_busy_o         : a scan is in progress (slave -> master)
//   query_done_o         : one-cycle pulse, result valid
//   query_hit_o          : cell occupied or outside the grid, held until next start
// -----------------------------------------------------------------------------
interface snake_body_tracker_if;
    logic       query_start_i;
    logic [4:0] query_x_i;
    logic [4:0] query_y_i;
    logic       query_busy_o;
    logic       query_done_o;
    logic       query_hit_o;

    modport master (
        output query_start_i, query_x_i, query_y_i,
        input  query_busy_o, query_done_o, query_hit_o
    );

    modport slave (
        input  query_start_i, query_x_i, query_y_i,
        output query_busy_o, query_done_o, query_hit_o
    );
endinterface

// File: rtl/snake_body_tracker.sv
// -----------------------------------------------------------------------------
// snake_body_tracker
//   Holds the snake segment coordinates on the playfield grid, advances them on
//   move ticks (with direction changes and growth), flags wall and self
//   collisions, and answers serial occupancy queries.
//
//   clk_i           : clock, rising edge
//   reset_i         : asynchronous active-low reset
//   move_tick_i     : one-cycle pulse, advance the snake one cell
//   dir_i           : requested direction (00 up, 01 down, 10 left, 11 right)
//   grow_i          : one-cycle pulse, next executed move grows the snake
//   qry             : occupancy-query handshake (slave side)
//   head_x_o/head_y_o : current head cell
//   length_o        : current segment count
//   wall_collide_o  : sticky wall-collision flag
//   self_collide_o  : sticky self-collision flag
//   game_over_o     : OR of the collision flags
// -----------------------------------------------------------------------------
module snake_body_tracker #(
    parameter int MAX_LEN  = 32,
    parameter int GRID_W   = 19,
    parameter int GRID_H   = 13,
    parameter int INIT_LEN = 3,
    parameter int INIT_X   = 5,
    parameter int INIT_Y   = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 move_tick_i,
    input  logic [1:0]           dir_i,
    input  logic                 grow_i,
    snake_body_tracker_if.slave  qry,
    output logic [4:0]           head_x_o,
    output logic [4:0]           head_y_o,
    output logic [5:0]           length_o,
    output logic                 wall_collide_o,
    output logic                 self_collide_o,
    output logic                 game_over_o
);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    typedef enum logic {ST_IDLE, ST_SCAN} q_state_t;

    logic [4:0]       seg_x_q [MAX_LEN];
    logic [4:0]       seg_x_d [MAX_LEN];
    logic [4:0]       seg_y_q [MAX_LEN];
    logic [4:0]       seg_y_d [MAX_LEN];
    logic [1:0]       dir_q, dir_d;
    logic [5:0]       len_q, len_d;
    logic             grow_pend_q, grow_pend_d;
    logic             move_pend_q, move_pend_d;
    logic             wall_q, wall_d;
    logic             self_q, self_d;

    q_state_t         state_q, state_d;
    logic [4:0]       qx_q, qx_d;
    logic [4:0]       qy_q, qy_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;

    logic             game_over;
    logic             busy;
    logic             exec_move;
    logic             growing;
    logic [1:0]       eff_dir;
    logic [4:0]       nx, ny;
    logic             wall_hit;
    logic             self_hit;

    assign game_over = wall_q | self_q;
    assign busy      = (state_q == ST_SCAN);
    // Moves are held off for the whole scan so the scan sees a frozen body;
    // a tick seen while busy is replayed from move_pend_q once busy drops.
    assign exec_move = !game_over && !busy && (move_tick_i || move_pend_q);
    assign growing   = grow_i | grow_pend_q;
    // Reversal pairs differ only in bit 0 (up/down, left/right).
    assign eff_dir   = (dir_i == (dir_q ^ 2'b01)) ? dir_q : dir_i;

    // Candidate head cell and wall check for the effective direction.
    always_comb begin
        wall_hit = 1'b0;
        nx       = seg_x_q[0];
        ny       = seg_y_q[0];
        case (eff_dir)
            DIR_UP: begin
                wall_hit = (seg_y_q[0] == 5'd0);
                ny       = seg_y_q[0] - 5'd1;
            end
            DIR_DOWN: begin
                wall_hit = (seg_y_q[0] == 5'(GRID_H - 1));
                ny       = seg_y_q[0] + 5'd1;
            end
            DIR_LEFT: begin
                wall_hit = (seg_x_q[0] == 5'd0);
                nx       = seg_x_q[0] - 5'd1;
            end
            default: begin
                wall_hit = (seg_x_q[0] == 5'(GRID_W - 1));
                nx       = seg_x_q[0] + 5'd1;
            end
        endcase
    end

    // The tail vacates its cell on a plain move, so it only counts as an
    // obstacle when this move grows the snake.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((seg_x_q[i] == nx) && (seg_y_q[i] == ny) &&
                ((i < int'(len_q) - 1) || (growing && (i == int'(len_q) - 1)))) begin
                self_hit = 1'b1;
            end
        end
    end

    // Body, direction, growth and collision next state.
    always_comb begin
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        dir_d       = dir_q;
        len_d       = len_q;
        grow_pend_d = grow_pend_q;
        move_pend_d = move_pend_q;
        wall_d      = wall_q;
        self_d      = self_q;
        if (exec_move) begin
            dir_d       = eff_dir;
            grow_pend_d = 1'b0;
            move_pend_d = 1'b0;
            if (wall_hit) begin
                wall_d = 1'b1;
            end else if (self_hit) begin
                self_d = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nx;
                seg_y_d[0] = ny;
                if (growing && (len_q < 6'(MAX_LEN))) begin
                    len_d = len_q + 6'd1;
                end
            end
        end else if (!game_over) begin
            if (grow_i) begin
                grow_pend_d = 1'b1;
            end
            if (move_tick_i && busy) begin
                move_pend_d = 1'b1;
            end
        end
    end

    // Query FSM: one segment compared per cycle, head first.
    always_comb begin
        state_d = state_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        hit_d   = hit_q;
        case (state_q)
            ST_IDLE: begin
                if (qry.query_start_i) begin
                    qx_d    = qry.query_x_i;
                    qy_d    = qry.query_y_i;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if ((qx_q >= 5'(GRID_W)) || (qy_q >= 5'(GRID_H))) begin
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if ((seg_x_q[idx_q] == qx_q) && (seg_y_q[idx_q] == qy_q)) begin
                    done_d  = 1'b1;
                    hit_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (6'(idx_q) == (len_q - 6'd1)) begin
                    done_d  = 1'b1;
                    hit_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= (i < INIT_LEN) ? 5'(INIT_X - i) : 5'd0;
                seg_y_q[i] <= (i < INIT_LEN) ? 5'(INIT_Y) : 5'd0;
            end
            dir_q       <= DIR_RIGHT;
            len_q       <= 6'(INIT_LEN);
            grow_pend_q <= 1'b0;
            move_pend_q <= 1'b0;
            wall_q      <= 1'b0;
            self_q      <= 1'b0;
            state_q     <= ST_IDLE;
            qx_q        <= '0;
            qy_q        <= '0;
            idx_q       <= '0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
        end else begin
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            grow_pend_q <= grow_pend_d;
            move_pend_q <= move_pend_d;
            wall_q      <= wall_d;
            self_q      <= self_d;
            state_q     <= state_d;
            qx_q        <= qx_d;
            qy_q        <= qy_d;
            idx_q       <= idx_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
        end
    end

    assign qry.query_busy_o = busy;
    assign qry.query_done_o = done_q;
    assign qry.query_hit_o  = hit_q;
    assign head_x_o         = seg_x_q[0];
    assign head_y_o         = seg_y_q[0];
    assign length_o         = len_q;
    assign wall_collide_o   = wall_q;
    assign self_collide_o   = self_q;
    assign game_over_o      = game_over;
endmodule

// File: tb/tb_snake_body_tracker.sv
// -----------------------------------------------------------------------------
// tb_snake_body_tracker
//   Self-checking bench: a queue-based model of the snake body and query
//   latency is compared with the DUT on every negative clock edge, and directed
//   scenarios pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_snake_body_tracker;
    localparam int MAX_LEN  = 32;
    localparam int GW       = 19;
    localparam int GH       = 13;
    localparam int INIT_LEN = 3;
    localparam int INIT_X   = 5;
    localparam int INIT_Y   = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       move_tick = 1'b0;
    logic [1:0] dir = 2'b11;
    logic       grow = 1'b0;
    logic [4:0] head_x, head_y;
    logic [5:0] length;
    logic       wall_c, self_c, game_over;

    snake_body_tracker_if qif();

    snake_body_tracker #(
        .MAX_LEN(MAX_LEN), .GRID_W(GW), .GRID_H(GH),
        .INIT_LEN(INIT_LEN), .INIT_X(INIT_X), .INIT_Y(INIT_Y)
    ) dut (
        .clk_i          (clk),
        .reset_i        (rst_n),
        .move_tick_i    (move_tick),
        .dir_i          (dir),
        .grow_i         (grow),
        .qry            (qif),
        .head_x_o       (head_x),
        .head_y_o       (head_y),
        .length_o       (length),
        .wall_collide_o (wall_c),
        .self_collide_o (self_c),
        .game_over_o    (game_over)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // ---------------- behavioural model ----------------
    int sx[$];
    int sy[$];
    int mdir;
    bit mgp, mmp, mwall, mself;
    bit qbusy, mdone, mhit, qres;
    int qcnt;

    task automatic model_reset();
        sx.delete();
        sy.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            sx.push_back(INIT_X - i);
            sy.push_back(INIT_Y);
        end
        mdir = 3; mgp = 0; mmp = 0; mwall = 0; mself = 0;
        qbusy = 0; mdone = 0; mhit = 0; qres = 0; qcnt = 0;
    endtask

    // Result and latency of a query against the current body.
    task automatic query_eval(input int x, input int y, output bit res, output int lat);
        res = 0;
        lat = sx.size();
        if (x >= GW || y >= GH) begin
            res = 1; lat = 1;
        end else begin
            for (int k = 0; k < sx.size(); k++) begin
                if (sx[k] == x && sy[k] == y) begin
                    res = 1; lat = k + 1;
                    break;
                end
            end
        end
    endtask

    task automatic model_step();
        bit go, grw, hitb;
        int ed, nx, ny, lim;
        go = mwall | mself;
        mdone = 0;
        if (!go && !qbusy && (move_tick || mmp)) begin
            grw = grow | mgp;
            ed  = int'(dir);
            if ((mdir == 0 && ed == 1) || (mdir == 1 && ed == 0) ||
                (mdir == 2 && ed == 3) || (mdir == 3 && ed == 2)) ed = mdir;
            nx = sx[0]; ny = sy[0];
            case (ed)
                0: ny = ny - 1;
                1: ny = ny + 1;
                2: nx = nx - 1;
                default: nx = nx + 1;
            endcase
            mdir = ed; mgp = 0; mmp = 0;
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
                mwall = 1;
            end else begin
                hitb = 0;
                lim  = grw ? sx.size() : sx.size() - 1;
                for (int k = 0; k < lim; k++)
                    if (sx[k] == nx && sy[k] == ny) hitb = 1;
                if (hitb) begin
                    mself = 1;
                end else begin
                    sx.push_front(nx);
                    sy.push_front(ny);
                    if (!(grw && sx.size() <= MAX_LEN)) begin
                        void'(sx.pop_back());
                        void'(sy.pop_back());
                    end
                end
            end
        end else if (!go) begin
            if (grow) mgp = 1;
            if (move_tick && qbusy) mmp = 1;
        end
        if (qbusy) begin
            qcnt--;
            if (qcnt == 0) begin
                qbusy = 0; mdone = 1; mhit = qres;
            end
        end else if (qif.query_start_i) begin
            query_eval(int'(qif.query_x_i), int'(qif.query_y_i), qres, qcnt);
            qbusy = 1; mhit = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [21:0] act, exp_v;
        if (chk_en) begin
            act   = {head_x, head_y, length, wall_c, self_c, game_over,
                     qif.query_busy_o, qif.query_done_o, qif.query_hit_o};
            exp_v = {5'(sx[0]), 5'(sy[0]), 6'(sx.size()), mwall, mself, mwall | mself,
                     qbusy, mdone, mhit};
            checks++;
            if (act !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual head=(%0d,%0d) len=%0d w=%0b s=%0b go=%0b busy=%0b done=%0b hit=%0b required head=(%0d,%0d) len=%0d w=%0b s=%0b go=%0b busy=%0b done=%0b hit=%0b",
                    $time, act[21:17], act[16:12], act[11:6], act[5], act[4], act[3], act[2], act[1], act[0],
                    exp_v[21:17], exp_v[16:12], exp_v[11:6], exp_v[5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Called at a negedge; reset asserted and released away from clock edges.
    task automatic apply_reset();
        move_tick = 0; grow = 0; qif.query_start_i = 0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_tick(input logic [1:0] d, input bit g);
        move_tick = 1; dir = d; grow = g;
        @(negedge clk);
        move_tick = 0; grow = 0;
    endtask

    task automatic do_query(input int x, input int y, output int hit, output int lat);
        qif.query_start_i = 1;
        qif.query_x_i = 5'(x);
        qif.query_y_i = 5'(y);
        @(negedge clk);
        qif.query_start_i = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!qif.query_done_o && lat < 100);
        if (!qif.query_done_o) chk("query_timeout", 0, 1);
        hit = int'(qif.query_hit_o);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hit, lat, n, r, k, go_cnt;
        qif.query_start_i = 0;
        qif.query_x_i = '0;
        qif.query_y_i = '0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // Reset state and basic queries
        chk("reset_head_x", head_x, 5);
        chk("reset_head_y", head_y, 6);
        chk("reset_len", length, 3);
        chk("reset_flags", {wall_c, self_c, game_over, qif.query_busy_o, qif.query_done_o, qif.query_hit_o}, 0);
        do_query(3, 6, hit, lat);
        chk("q_tail_hit", hit, 1);
        chk("q_tail_lat", lat, 3);
        do_query(6, 6, hit, lat);
        chk("q_empty_hit", hit, 0);
        chk("q_empty_lat", lat, 3);
        do_query(19, 0, hit, lat);
        chk("q_oog_hit", hit, 1);
        chk("q_oog_lat", lat, 1);

        // Moves and reversal
        do_tick(2'b11, 0);
        chk("mv_right_x", head_x, 6);
        do_tick(2'b10, 0);
        chk("mv_rev_x", head_x, 7);
        chk("mv_rev_y", head_y, 6);
        do_tick(2'b00, 0);
        chk("mv_up_x", head_x, 7);
        chk("mv_up_y", head_y, 5);

        // Growth via pending request
        apply_reset();
        grow = 1; @(negedge clk); grow = 0;
        do_tick(2'b11, 0);
        chk("grow_len", length, 4);
        chk("grow_head_x", head_x, 6);
        do_query(3, 6, hit, lat);
        chk("grow_tail_kept", hit, 1);
        chk("grow_tail_lat", lat, 4);

        // Wall collision
        apply_reset();
        for (int i = 0; i < 13; i++) do_tick(2'b11, 0);
        chk("wall_pre_x", head_x, 18);
        chk("wall_pre_flag", wall_c, 0);
        do_tick(2'b11, 0);
        chk("wall_flag", wall_c, 1);
        chk("wall_go", game_over, 1);
        chk("wall_head_x", head_x, 18);
        do_tick(2'b00, 1);
        chk("wall_ignored_y", head_y, 6);
        chk("wall_ignored_len", length, 3);

        // Self collision
        apply_reset();
        do_tick(2'b11, 1);
        do_tick(2'b11, 1);
        chk("self_len5", length, 5);
        do_tick(2'b00, 0);
        do_tick(2'b10, 0);
        do_tick(2'b01, 0);
        chk("self_flag", self_c, 1);
        chk("self_go", game_over, 1);
        chk("self_head_x", head_x, 6);
        chk("self_head_y", head_y, 5);

        // Tick during scan is deferred until after done
        apply_reset();
        qif.query_start_i = 1; qif.query_x_i = 5'd10; qif.query_y_i = 5'd10;
        @(negedge clk);
        qif.query_start_i = 0;
        move_tick = 1; dir = 2'b11;
        @(negedge clk);
        move_tick = 0;
        n = 1;
        while (!qif.query_done_o && n < 50) begin
            chk("scan_frozen_x", head_x, 5);
            @(negedge clk);
            n++;
        end
        chk("scan_lat", n, 3);
        chk("scan_done_head_x", head_x, 5);
        @(negedge clk);
        chk("scan_after_head_x", head_x, 6);

        // Reset during a scan aborts it
        qif.query_start_i = 1; qif.query_x_i = 5'd10; qif.query_y_i = 5'd10;
        @(negedge clk);
        qif.query_start_i = 0;
        chk("abort_busy_pre", qif.query_busy_o, 1);
        apply_reset();
        chk("abort_busy", qif.query_busy_o, 0);
        chk("abort_done", qif.query_done_o, 0);

        // Length saturation
        for (int i = 0; i < 13; i++) do_tick(2'b11, 1);
        for (int i = 0; i < 6; i++)  do_tick(2'b01, 1);
        for (int i = 0; i < 17; i++) do_tick(2'b10, 1);
        chk("sat_len", length, 32);
        chk("sat_head_x", head_x, 1);
        chk("sat_head_y", head_y, 12);
        chk("sat_no_collide", game_over, 0);

        // Randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            apply_reset();
            go_cnt = 0;
            for (int c = 0; c < 400; c++) begin
                move_tick = ($urandom_range(0, 3) == 0);
                dir = 2'($urandom_range(0, 3));
                grow = ($urandom_range(0, 5) == 0);
                qif.query_start_i = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 9);
                if (r < 4) begin
                    k = $urandom_range(0, sx.size() - 1);
                    qif.query_x_i = 5'(sx[k]);
                    qif.query_y_i = 5'(sy[k]);
                end else if (r < 8) begin
                    qif.query_x_i = 5'($urandom_range(0, GW - 1));
                    qif.query_y_i = 5'($urandom_range(0, GH - 1));
                end else begin
                    qif.query_x_i = 5'($urandom_range(0, 31));
                    qif.query_y_i = 5'($urandom_range(0, 31));
                end
                @(negedge clk);
                if (mwall | mself) go_cnt++;
                if (go_cnt > 15) break;
            end
        end
        move_tick = 0; grow = 0; qif.query_start_i = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
